// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch pc, fills the IF/ID register from a
// combinational instruction memory, and handles stall, redirect and fault pulses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instruction_code,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misalign_fault,
  output logic        range_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] WORDS_LIMIT      = 32'(IMEM_WORDS);

  typedef enum logic [1:0] {
    ACT_REDIRECT,
    ACT_STALL,
    ACT_ADVANCE
  } action_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  action_e     action;
  if_id_t      if_id_q, if_id_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        misalign_d, range_d;
  logic        in_range;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;  // wraps naturally at 2^32
  assign in_range = {2'b00, pc_q[31:2]} < WORDS_LIMIT;

  always_comb begin
    if (redirect_valid)  action = ACT_REDIRECT;
    else if (stall)      action = ACT_STALL;
    else                 action = ACT_ADVANCE;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    pc_d       = pc_q;
    if_id_d    = if_id_q;
    count_d    = count_q;
    misalign_d = 1'b0;
    range_d    = 1'b0;
    unique case (action)
      ACT_REDIRECT: begin
        pc_d          = {redirect_target[31:2], 2'b00};
        if_id_d.instr = NOP_INSTR;
        if_id_d.valid = 1'b0;
        misalign_d    = (redirect_target[1:0] != 2'b00);
      end
      ACT_ADVANCE: begin
        pc_d             = pc_plus4;
        if_id_d.pc       = pc_q;
        if_id_d.pc_plus4 = pc_plus4;
        if (in_range) begin
          if_id_d.instr = instruction_code;
          if_id_d.valid = 1'b1;
          if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
        end else begin
          if_id_d.instr = NOP_INSTR;
          if_id_d.valid = 1'b0;
          range_d       = 1'b1;
        end
      end
      default: ;  // stall: everything holds
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC_ALIGNED;
      if_id_q        <= '{pc: 32'h0, pc_plus4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
      count_q        <= 32'h0;
      misalign_fault <= 1'b0;
      range_fault    <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      if_id_q        <= if_id_d;
      count_q        <= count_d;
      misalign_fault <= misalign_d;
      range_fault    <= range_d;
    end
  end

  assign pc             = pc_q;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_valid    = if_id_q.valid;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, wrap/range instance,
// asynchronous reset, and randomized traffic against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          WORDS = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect_valid;
  logic [31:0] redirect_target, instruction_code;
  logic [31:0] pc, if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count;
  logic        if_id_valid, misalign_fault, range_fault;

  logic        rst_w_n;
  logic [31:0] instr_w, pc_w, if_id_pc_w, if_id_pc_plus4_w, if_id_instr_w, fetch_count_w;
  logic        if_id_valid_w, misalign_fault_w, range_fault_w;

  logic [31:0] imem [WORDS];

  assign instruction_code = (pc[31:2] < 30'(WORDS)) ? imem[pc[11:2]] : 32'hDEAD_BEEF;
  assign instr_w          = (pc_w[31:2] < 30'(WORDS)) ? imem[pc_w[11:2]] : 32'hDEAD_BEEF;

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(WORDS), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .instruction_code(instruction_code),
    .pc(pc), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .misalign_fault(misalign_fault), .range_fault(range_fault), .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(WORDS), .NOP_INSTR(NOP)) dut_w (
    .clk(clk), .rst_n(rst_w_n), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_target(32'h0), .instruction_code(instr_w),
    .pc(pc_w), .if_id_pc(if_id_pc_w), .if_id_pc_plus4(if_id_pc_plus4_w),
    .if_id_instr(if_id_instr_w), .if_id_valid(if_id_valid_w),
    .misalign_fault(misalign_fault_w), .range_fault(range_fault_w), .fetch_count(fetch_count_w)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                             input logic [31:0] e_plus4, input logic [31:0] e_instr,
                             input logic e_valid, input logic e_mis, input logic e_rng,
                             input logic [31:0] e_cnt);
    check({tag, ".pc"},       pc,                    e_pc);
    check({tag, ".if_pc"},    if_id_pc,              e_ifpc);
    check({tag, ".plus4"},    if_id_pc_plus4,        e_plus4);
    check({tag, ".instr"},    if_id_instr,           e_instr);
    check({tag, ".valid"},    32'(if_id_valid),      32'(e_valid));
    check({tag, ".misalign"}, 32'(misalign_fault),   32'(e_mis));
    check({tag, ".range"},    32'(range_fault),      32'(e_rng));
    check({tag, ".count"},    fetch_count,           e_cnt);
  endtask

  // Behavioural model: one call per rising edge, applying the redirect/stall/advance rules.
  logic [31:0] m_pc, m_ifpc, m_plus4, m_instr, m_cnt;
  logic        m_valid, m_mis, m_rng;

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_plus4 = 32'h0; m_instr = NOP;
    m_valid = 1'b0; m_mis = 1'b0; m_rng = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [31:0] t);
    m_mis = 1'b0;
    m_rng = 1'b0;
    if (r) begin
      m_mis   = (t % 4) != 0;
      m_pc    = t - (t % 4);
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (!s) begin
      m_ifpc  = m_pc;
      m_plus4 = m_pc + 32'd4;
      if ((m_pc / 4) < 32'(WORDS)) begin
        m_instr = imem[(m_pc / 4) % WORDS];
        m_valid = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else begin
        m_instr = NOP;
        m_valid = 1'b0;
        m_rng   = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, return at the next falling edge.
  task automatic cycle(input logic s, input logic r, input logic [31:0] t);
    stall = s; redirect_valid = r; redirect_target = t;
    @(posedge clk);
    model_step(s, r, t);
    @(negedge clk);
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic [31:0] e_pc;
    logic [31:0] e_ifpc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic random_run(input int n, input string tag);
    logic        s, r;
    logic [31:0] t;
    for (int k = 0; k < n; k++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       t = 32'($urandom_range(0, 32'h0FFF));
        1:       t = 32'h0000_0FF0 + 32'($urandom_range(0, 31));
        2:       t = $urandom;
        default: t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
      cycle(s, r, t);
      check_state(tag, m_pc, m_ifpc, m_plus4, m_instr, m_valid, m_mis, m_rng, m_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) imem[i] = 32'hA0A0_0000 + 32'(i);

    vecs[0]  = '{1'b0, 1'b0, 32'h0,   32'h4,   32'h0,   32'hA0A0_0000, 1'b1, 1'b0, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   32'h8,   32'h4,   32'hA0A0_0001, 1'b1, 1'b0, 32'd2};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,   32'h8,   32'h4,   32'hA0A0_0001, 1'b1, 1'b0, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   32'h8,   32'h4,   32'hA0A0_0001, 1'b1, 1'b0, 32'd2};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   32'h8,   32'h4,   32'hA0A0_0001, 1'b1, 1'b0, 32'd2};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   32'hC,   32'h8,   32'hA0A0_0002, 1'b1, 1'b0, 32'd3};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   32'h10,  32'hC,   32'hA0A0_0003, 1'b1, 1'b0, 32'd4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   32'h14,  32'h10,  32'hA0A0_0004, 1'b1, 1'b0, 32'd5};
    vecs[8]  = '{1'b1, 1'b1, 32'h40,  32'h40,  32'h10,  NOP,           1'b0, 1'b0, 32'd5};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   32'h44,  32'h40,  32'hA0A0_0010, 1'b1, 1'b0, 32'd6};
    vecs[10] = '{1'b0, 1'b1, 32'h106, 32'h104, 32'h40,  NOP,           1'b0, 1'b1, 32'd6};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   32'h108, 32'h104, 32'hA0A0_0041, 1'b1, 1'b0, 32'd7};
    vecs[12] = '{1'b1, 1'b0, 32'h0,   32'h108, 32'h104, 32'hA0A0_0041, 1'b1, 1'b0, 32'd7};

    rst_n = 1'b0; rst_w_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    model_reset();
    #23;
    check_state("reset", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'h0);
    check("reset_w.pc", pc_w, 32'hFFFF_FFFC);

    @(negedge clk);
    rst_n = 1'b1; rst_w_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].stall, vecs[i].redir, vecs[i].target);
      check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ifpc, vecs[i].e_ifpc + 32'd4,
                  vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_mis, 1'b0, vecs[i].e_cnt);
      if (i == 0) begin
        check("wrap0.pc",    pc_w,                32'h0);
        check("wrap0.if_pc", if_id_pc_w,          32'hFFFF_FFFC);
        check("wrap0.plus4", if_id_pc_plus4_w,    32'h0);
        check("wrap0.instr", if_id_instr_w,       NOP);
        check("wrap0.valid", 32'(if_id_valid_w),  32'h0);
        check("wrap0.range", 32'(range_fault_w),  32'h1);
        check("wrap0.count", fetch_count_w,       32'h0);
      end
      if (i == 1) begin
        check("wrap1.pc",    pc_w,                32'h4);
        check("wrap1.if_pc", if_id_pc_w,          32'h0);
        check("wrap1.instr", if_id_instr_w,       32'hA0A0_0000);
        check("wrap1.valid", 32'(if_id_valid_w),  32'h1);
        check("wrap1.range", 32'(range_fault_w),  32'h0);
        check("wrap1.count", fetch_count_w,       32'h1);
      end
    end

    for (int i = 0; i < WORDS; i++) imem[i] = $urandom;
    random_run(300, "rand1");

    // Asynchronous reset between edges, with redirect and stall active during reset.
    @(posedge clk);
    #2 rst_n = 1'b0;
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
    #1;
    check_state("async_rst", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state("rst_hold", 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    check_state("post_rst", 32'h4, 32'h0, 32'h4, imem[0], 1'b1, 1'b0, 1'b0, 32'h1);

    random_run(300, "rand2");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 The block SHALL have parameter IMEM_WORDS, default 1024, which is the number of instruction memory words; word indices at or above it are out of range.
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), which is the bubble instruction.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port stall, input, 1 bit: the downstream stage cannot accept a new instruction.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: branch/jump taken, flush and refetch.
REQ-008 The block SHALL have port redirect_target, input, 32 bits: the new fetch byte address.
REQ-009 The block SHALL have port instruction_code, input, 32 bits: combinational read data from the instruction memory for the current pc.
REQ-010 The block SHALL have port pc, output, 32 bits: the current fetch byte address driven to the instruction memory.
REQ-011 The block SHALL have port if_id_pc, output, 32 bits: the address of the instruction held in IF/ID.
REQ-012 The block SHALL have port if_id_pc_plus4, output, 32 bits: if_id_pc + 4 (mod 2^32), registered.
REQ-013 The block SHALL have port if_id_instr, output, 32 bits: the instruction held in IF/ID.
REQ-014 The block SHALL have port if_id_valid, output, 1 bit: IF/ID holds a real instruction.
REQ-015 The block SHALL have port misalign_fault, output, 1 bit: a one-cycle pulse, registered.
REQ-016 The block SHALL have port range_fault, output, 1 bit: a one-cycle pulse, registered.
REQ-017 The block SHALL have port fetch_count, output, 32 bits: the number of valid instructions delivered to IF/ID.

Function
REQ-018 The pc register SHALL be the only fetch address source; pc[1:0] SHALL always be 2'b00.
REQ-019 Each rising edge SHALL apply exactly one of the following, in priority order: redirect, stall, advance.
REQ-020 On redirect (redirect_valid=1, regardless of stall), pc SHALL be set to {redirect_target[31:2],2'b00}, if_id_valid to 0 and if_id_instr to NOP_INSTR; if_id_pc and if_id_pc_plus4 SHALL be held and fetch_count SHALL be unchanged.
REQ-021 On redirect, misalign_fault SHALL pulse high for one cycle when redirect_target[1:0] != 0, otherwise it SHALL be 0.
REQ-022 On stall (stall=1, redirect_valid=0), pc and all if_id_* registers SHALL hold and fetch_count SHALL hold.
REQ-023 On advance (stall=0, redirect_valid=0) with pc[31:2] < IMEM_WORDS, IF/ID SHALL capture {pc, pc+4, instruction_code}, if_id_valid SHALL be set to 1, pc SHALL be set to pc+4, and fetch_count SHALL increment.
REQ-024 On advance with pc[31:2] >= IMEM_WORDS, IF/ID SHALL capture {pc, pc+4, NOP_INSTR} with if_id_valid=0, range_fault SHALL pulse for one cycle, pc SHALL still advance by 4, and fetch_count SHALL be unchanged.
REQ-025 pc+4 arithmetic SHALL be 32-bit and wrap: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-026 fetch_count SHALL saturate at 32'hFFFF_FFFF.
REQ-027 misalign_fault and range_fault SHALL be 0 on every edge that does not set them.
REQ-028 The latency from pc presented to the instruction appearing on if_id_instr SHALL be 1 clock.
REQ-029 No output SHALL depend combinationally on stall, redirect_valid or instruction_code; all outputs SHALL be registered.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force pc=RESET_PC (aligned), if_id_pc=0, if_id_pc_plus4=0, if_id_instr=NOP_INSTR, if_id_valid=0, misalign_fault=0, range_fault=0 and fetch_count=0, independent of clk.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard that operation.
REQ-032 The first edge after rst_n rises SHALL be evaluated per REQ-019.

Verification
REQ-033 The bench SHALL cover sequential fetch: reset, release, no stall, memory words 0..3 = A0,A1,A2,A3 -> edges 1..4 give if_id_pc 0,4,8,C with the matching instruction, if_id_valid=1, and fetch_count=4.
REQ-034 The bench SHALL cover stall: stall=1 for 3 cycles after if_id_pc=4 -> pc stays 8, IF/ID holds A1, fetch_count is frozen; after release the next instruction is A2.
REQ-035 The bench SHALL cover redirect-over-stall: redirect_valid=1, target=32'h40, with stall=1 -> next edge gives pc=0x40, if_id_valid=0, if_id_instr=NOP_INSTR; the following edge gives if_id_pc=0x40.
REQ-036 The bench SHALL cover misaligned redirect: target=32'h0000_0106 -> pc=0x104 and a misalign_fault pulse of exactly 1 cycle.
REQ-037 The bench SHALL cover range and wrap: RESET_PC=32'hFFFF_FFFC with IMEM_WORDS=1024 -> first edge gives range_fault=1, if_id_valid=0, pc=0; the next edge gives a valid fetch of word 0.
REQ-038 The bench SHALL cover asynchronous reset: rst_n pulled low between clock edges during a run -> all outputs reach their reset values before the next clk edge.
